// File: rtl/led_matrix_pkg.sv
// Shared scan-state type and width helpers for the LED matrix scanner.
// Widths are derived from parameters; helpers never return zero width.
package led_matrix_pkg;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } scan_state_t;

    // Index width for a range of n values, at least 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/led_frame_ram.sv
// Frame buffer: one synchronous write port, one registered read port; no reset.
// Read-during-write to the same entry returns the old contents.
module led_frame_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed row/panel scanner for LED matrices sharing one row bus.
// Pins lag the scan counters by one cycle; the frame RAM is read one cycle ahead.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int NUM_PANELS = 2,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int NUM_FRAMES = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int BLANK      = 16,
    parameter int FRAME_HOLD = 30
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic [cnt_w(NUM_FRAMES)-1:0]    num_frames,
    input  logic                            wr_en,
    input  logic [idx_w(NUM_FRAMES)-1:0]    wr_frame,
    input  logic [idx_w(NUM_PANELS)-1:0]    wr_panel,
    input  logic [idx_w(ROWS)-1:0]          wr_row,
    input  logic [COLS-1:0]                 wr_data,
    output logic [ROWS-1:0]                 row,
    output logic [NUM_PANELS*COLS-1:0]      col,
    output logic [idx_w(NUM_FRAMES)-1:0]    frame_idx,
    output logic                            frame_done
);

    localparam int FW    = idx_w(NUM_FRAMES);
    localparam int PW    = idx_w(NUM_PANELS);
    localparam int RW    = idx_w(ROWS);
    localparam int CW    = idx_w(SCAN_DIV);
    localparam int SW    = idx_w(FRAME_HOLD);
    localparam int NW    = cnt_w(NUM_FRAMES);
    localparam int DEPTH = NUM_FRAMES * NUM_PANELS * ROWS;
    localparam int AW    = idx_w(DEPTH);

    localparam logic [CW-1:0] CYC_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PNL_LAST  = PW'(NUM_PANELS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(FRAME_HOLD - 1);

    logic [CW-1:0] r_cyc,     w_cyc_nxt;
    logic [PW-1:0] r_pnl,     w_pnl_nxt;
    logic [RW-1:0] r_row_cnt, w_row_nxt;
    logic [SW-1:0] r_scan,    w_scan_nxt;
    logic [FW-1:0] r_frame,   w_frame_nxt;
    scan_state_t   r_state,   w_state_nxt;

    logic                       w_adv;
    logic [NW-1:0]              w_eff;
    logic [AW-1:0]              w_rd_addr;
    logic [AW-1:0]              w_wr_addr;
    logic [COLS-1:0]            w_ram_q;
    logic [NUM_PANELS*COLS-1:0] w_col_drv;

    logic [ROWS-1:0]            r_row_q;
    logic [NUM_PANELS*COLS-1:0] r_col_q;
    logic                       r_frame_done;

    always_comb begin
        w_eff = num_frames;
        if (num_frames == '0) begin
            w_eff = NW'(1);
        end else if (num_frames > NW'(NUM_FRAMES)) begin
            w_eff = NW'(NUM_FRAMES);
        end
    end

    // Counter chain: cycle -> panel -> row -> scan -> frame.
    always_comb begin
        w_cyc_nxt   = r_cyc;
        w_pnl_nxt   = r_pnl;
        w_row_nxt   = r_row_cnt;
        w_scan_nxt  = r_scan;
        w_frame_nxt = r_frame;
        w_adv       = 1'b0;
        if (!reset) begin
            w_cyc_nxt   = '0;
            w_pnl_nxt   = '0;
            w_row_nxt   = '0;
            w_scan_nxt  = '0;
            w_frame_nxt = '0;
        end else if (en) begin
            if (r_cyc == CYC_LAST) begin
                w_cyc_nxt = '0;
                if (r_pnl == PNL_LAST) begin
                    w_pnl_nxt = '0;
                    if (r_row_cnt == ROW_LAST) begin
                        w_row_nxt = '0;
                        if (r_scan == SCAN_LAST) begin
                            w_scan_nxt = '0;
                            w_adv      = 1'b1;
                            if ((NW'(r_frame) + NW'(1)) >= w_eff) begin
                                w_frame_nxt = '0;
                            end else begin
                                w_frame_nxt = r_frame + FW'(1);
                            end
                        end else begin
                            w_scan_nxt = r_scan + SW'(1);
                        end
                    end else begin
                        w_row_nxt = r_row_cnt + RW'(1);
                    end
                end else begin
                    w_pnl_nxt = r_pnl + PW'(1);
                end
            end else begin
                w_cyc_nxt = r_cyc + CW'(1);
            end
        end
        w_state_nxt = (int'(w_cyc_nxt) < BLANK) ? ST_BLANK : ST_DRIVE;
    end

    always_ff @(posedge clk) begin
        r_cyc     <= w_cyc_nxt;
        r_pnl     <= w_pnl_nxt;
        r_row_cnt <= w_row_nxt;
        r_scan    <= w_scan_nxt;
        r_frame   <= w_frame_nxt;
        r_state   <= w_state_nxt;
    end

    // Address the next counter state so the RAM word is ready when the slot is current.
    assign w_rd_addr = AW'((int'(w_frame_nxt) * NUM_PANELS + int'(w_pnl_nxt)) * ROWS
                           + int'(w_row_nxt));
    assign w_wr_addr = AW'((int'(wr_frame) * NUM_PANELS + int'(wr_panel)) * ROWS
                           + int'(wr_row));

    led_frame_ram #(
        .DEPTH (DEPTH),
        .WIDTH (COLS),
        .AW    (AW)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    always_comb begin
        w_col_drv = '0;
        w_col_drv[int'(r_pnl)*COLS +: COLS] = w_ram_q;
    end

    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            r_row_q      <= '0;
            r_col_q      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_adv;
            if (r_state == ST_DRIVE) begin
                r_row_q <= ROWS'(1) << r_row_cnt;
                r_col_q <= w_col_drv;
            end else begin
                r_row_q <= '0;
                r_col_q <= '0;
            end
        end
    end

    assign row        = r_row_q;
    assign col        = r_col_q;
    assign frame_idx  = r_frame;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with a short scan (4-cycle slots, 2-scan frames).
// Expected pins come from a cycle-indexed scan model plus hand-computed spot values.
module tb_led_matrix_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  num_frames;
    logic        wr_en;
    logic [1:0]  wr_frame;
    logic [0:0]  wr_panel;
    logic [2:0]  wr_row;
    logic [7:0]  wr_data;
    logic [7:0]  row;
    logic [15:0] col;
    logic [1:0]  frame_idx;
    logic        frame_done;

    int total;
    int bad;
    int k;
    int cur;
    int abs_e;
    int last_pulse;
    int gap;
    logic [7:0] mem_m [4][2][8];

    led_matrix_scanner #(
        .NUM_PANELS (2),
        .ROWS       (8),
        .COLS       (8),
        .NUM_FRAMES (4),
        .SCAN_DIV   (4),
        .BLANK      (1),
        .FRAME_HOLD (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .num_frames (num_frames),
        .wr_en      (wr_en),
        .wr_frame   (wr_frame),
        .wr_panel   (wr_panel),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .row        (row),
        .col        (col),
        .frame_idx  (frame_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int n);
        return (n == 0) ? 1 : ((n > 4) ? 4 : n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock per iteration; output state after edge k reflects counter state k-1.
    task automatic tick(input int n, input bit do_chk);
        for (int i = 0; i < n; i++) begin
            logic [7:0]  er;
            logic [15:0] ec;
            logic        ed;
            int          og;
            int          slot;
            int          cf;
            @(posedge clk);
            #1;
            abs_e++;
            er = '0;
            ec = '0;
            ed = 1'b0;
            if (!reset) begin
                k   = 0;
                cur = 0;
            end else if (en) begin
                k++;
                cf = cur;
                if (k % 128 == 0) begin
                    cur = (cur + 1 >= eff(int'(num_frames))) ? 0 : cur + 1;
                    ed  = 1'b1;
                end
                og   = k - 1;
                slot = (og / 4) % 16;
                if (og % 4 != 0) begin
                    er = 8'(1 << (slot / 2));
                    ec = 16'(mem_m[cf][slot % 2][slot / 2]) << (8 * (slot % 2));
                end
            end
            if (frame_done === 1'b1) begin
                gap        = abs_e - last_pulse;
                last_pulse = abs_e;
            end
            if (do_chk) begin
                chk("row", 32'(row), 32'(er));
                chk("col", 32'(col), 32'(ec));
                chk("frame_idx", 32'(frame_idx), 32'(cur));
                chk("frame_done", 32'(frame_done), 32'(ed));
            end
        end
    endtask

    task automatic wr(input int f, input int p, input int r, input logic [7:0] d);
        wr_en    = 1'b1;
        wr_frame = 2'(f);
        wr_panel = 1'(p);
        wr_row   = 3'(r);
        wr_data  = d;
        tick(1, 1'b1);
        wr_en    = 1'b0;
        mem_m[f][p][r] = d;
    endtask

    initial begin
        logic [7:0] d;
        total = 0; bad = 0; k = 0; cur = 0; abs_e = 0; last_pulse = 0; gap = 0;
        reset = 1'b0; en = 1'b0; num_frames = 3'd1;
        wr_en = 1'b0; wr_frame = '0; wr_panel = '0; wr_row = '0; wr_data = '0;

        // Reset, then idle with en low while the buffer is loaded.
        tick(3, 1'b1);
        chk("rst_row", 32'(row), 32'h0);
        chk("rst_col", 32'(col), 32'h0);
        chk("rst_frame_idx", 32'(frame_idx), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b1;
        tick(3, 1'b1);
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < 2; p++) begin
                for (int r = 0; r < 8; r++) begin
                    d = 8'h01;
                    if (f == 0)      d = (p == 0) ? (d << r) : (8'h80 >> r);
                    else if (f == 1) d = 8'h0F;
                    else if (f == 2) d = 8'hF0;
                    else             d = 8'h3C;
                    wr(f, p, r, d);
                end
            end
        end
        chk("idle_row", 32'(row), 32'h0);

        // Basic scan, single frame.
        num_frames = 3'd1;
        en = 1'b1;
        tick(1, 1'b1);
        chk("s0_blank_row", 32'(row), 32'h0);
        tick(1, 1'b1);
        chk("s0_drive_row", 32'(row), 32'h01);
        chk("s0_drive_col", 32'(col), 32'h0001);
        tick(2, 1'b1);
        chk("s0_last_col", 32'(col), 32'h0001);
        tick(1, 1'b1);
        chk("s1_blank_col", 32'(col), 32'h0);
        tick(1, 1'b1);
        chk("s1_drive_row", 32'(row), 32'h01);
        chk("s1_drive_col", 32'(col), 32'h8000);
        tick(56, 1'b1);
        chk("s15_row", 32'(row), 32'h80);
        chk("s15_col", 32'(col), 32'h0100);
        tick(4, 1'b1);
        chk("rescan_row", 32'(row), 32'h01);
        chk("rescan_col", 32'(col), 32'h0001);
        tick(62, 1'b1);
        chk("nf1_done", 32'(frame_done), 32'h1);
        chk("nf1_idx", 32'(frame_idx), 32'h0);
        tick(12, 1'b1);

        // Frame advance over three pages.
        en = 1'b0;
        reset = 1'b0;
        tick(1, 1'b1);
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 8; r++) begin
                wr(0, p, r, 8'hFF);
            end
        end
        num_frames = 3'd3;
        en = 1'b1;
        tick(127, 1'b1);
        chk("fa_pre_done", 32'(frame_done), 32'h0);
        tick(1, 1'b1);
        chk("fa1_idx", 32'(frame_idx), 32'h1);
        chk("fa1_done", 32'(frame_done), 32'h1);
        tick(2, 1'b1);
        chk("fa1_col", 32'(col), 32'h000F);
        tick(126, 1'b1);
        chk("fa2_idx", 32'(frame_idx), 32'h2);
        chk("fa2_period", 32'(gap), 32'd128);
        tick(2, 1'b1);
        chk("fa2_col", 32'(col), 32'h00F0);
        tick(126, 1'b1);
        chk("fa3_idx", 32'(frame_idx), 32'h0);
        chk("fa3_done", 32'(frame_done), 32'h1);

        // Clamp: zero acts as one page, oversize acts as all pages.
        num_frames = 3'd0;
        tick(128, 1'b1);
        chk("nf0_idx", 32'(frame_idx), 32'h0);
        chk("nf0_done", 32'(frame_done), 32'h1);
        chk("nf0_period", 32'(gap), 32'd128);
        num_frames = 3'd7;
        for (int j = 1; j <= 4; j++) begin
            tick(128, 1'b1);
            chk("nf7_idx", 32'(frame_idx), 32'(j % 4));
        end

        // Freeze mid-DRIVE of slot 5 for 10 cycles.
        tick(86, 1'b1);
        chk("pre_frz_row", 32'(row), 32'h04);
        chk("pre_frz_col", 32'(col), 32'hFF00);
        en = 1'b0;
        tick(1, 1'b1);
        chk("frz_row", 32'(row), 32'h0);
        chk("frz_col", 32'(col), 32'h0);
        tick(9, 1'b1);
        en = 1'b1;
        tick(1, 1'b1);
        chk("resume_row", 32'(row), 32'h04);
        chk("resume_col", 32'(col), 32'hFF00);
        tick(41, 1'b1);
        chk("frz_done", 32'(frame_done), 32'h1);
        chk("frz_period", 32'(gap), 32'd138);

        // Live write during slot 7 DRIVE, then reset mid-scan.
        num_frames = 3'd1;
        reset = 1'b0;
        tick(1, 1'b1);
        reset = 1'b1;
        tick(29, 1'b1);
        wr_en = 1'b1; wr_frame = 2'd0; wr_panel = 1'b1; wr_row = 3'd3; wr_data = 8'hAA;
        tick(1, 1'b0);
        wr_en = 1'b0;
        tick(1, 1'b0);
        mem_m[0][1][3] = 8'hAA;
        tick(1, 1'b1);
        tick(62, 1'b1);
        chk("live_row", 32'(row), 32'h08);
        chk("live_col", 32'(col), 32'hAA00);
        tick(10, 1'b1);
        reset = 1'b0;
        tick(1, 1'b1);
        chk("mid_rst_row", 32'(row), 32'h0);
        chk("mid_rst_col", 32'(col), 32'h0);
        chk("mid_rst_idx", 32'(frame_idx), 32'h0);
        reset = 1'b1;
        tick(1, 1'b1);
        chk("restart_blank", 32'(row), 32'h0);
        tick(1, 1'b1);
        chk("restart_row", 32'(row), 32'h01);
        chk("restart_col", 32'(col), 32'h00FF);
        tick(29, 1'b1);
        chk("kept_col", 32'(col), 32'hAA00);
        tick(5, 1'b1);
        en = 1'b0;
        tick(2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
